// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate divider, programmable sync/porch
// timing, beam and lookahead coordinates, and a frame-boundary run/halt control.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0,
    parameter int CLK_DIV   = 2,
    parameter int LOOKAHEAD = 0,
    parameter int COL_W     = 10,
    parameter int ROW_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             pixEn,
    output logic             hSync,
    output logic             vSync,
    output logic             displayActive,
    output logic             fetchActive,
    output logic [COL_W-1:0] column,
    output logic [ROW_W-1:0] row,
    output logic             lineStart,
    output logic             frameStart
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int DW = $clog2(CLK_DIV + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] LA_H0    = HW'(LOOKAHEAD);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON    = (H_POL != 0);
    localparam logic          VS_ON    = (V_POL != 0);

    localparam logic [0:0] S_HALT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [DW-1:0]    divCnt_q, divCnt_d;
    logic [HW-1:0]    hCnt_q, hCnt_d, laH_q, laH_d;
    logic [VW-1:0]    vCnt_q, vCnt_d, laV_q, laV_d;
    logic             pixEn_q, pixEn_d, hSync_q, hSync_d, vSync_q, vSync_d;
    logic             dispAct_q, dispAct_d, fetchAct_q, fetchAct_d;
    logic [COL_W-1:0] column_q, column_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             lineStart_q, lineStart_d, frameStart_q, frameStart_d;
    logic             tick, running;

    always_comb begin
        tick     = (divCnt_q == DIV_LAST);
        divCnt_d = tick ? '0 : divCnt_q + 1'b1;
        state_d  = state_q;
        hCnt_d   = hCnt_q;
        vCnt_d   = vCnt_q;
        laH_d    = laH_q;
        laV_d    = laV_q;
        if (tick) begin
            if (state_q == S_HALT) begin
                if (run) state_d = S_RUN;
            end else begin
                if (hCnt_q == H_LAST) begin
                    hCnt_d = '0;
                    vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 1'b1;
                end else begin
                    hCnt_d = hCnt_q + 1'b1;
                end
                if (laH_q == H_LAST) begin
                    laH_d = '0;
                    laV_d = (laV_q == V_LAST) ? '0 : laV_q + 1'b1;
                end else begin
                    laH_d = laH_q + 1'b1;
                end
                // Halting tick wraps the lookahead to exactly (LOOKAHEAD,0), its HALT value.
                if (hCnt_q == H_LAST && vCnt_q == V_LAST && !run) state_d = S_HALT;
            end
        end

        // Outputs derive from next-state counters so they register on the same edge.
        running      = (state_d == S_RUN);
        pixEn_d      = tick;
        hSync_d      = (running && hCnt_d >= HS_BEG && hCnt_d < HS_END) ? HS_ON : ~HS_ON;
        vSync_d      = (running && vCnt_d >= VS_BEG && vCnt_d < VS_END) ? VS_ON : ~VS_ON;
        dispAct_d    = running && (hCnt_d < H_ACT) && (vCnt_d < V_ACT);
        fetchAct_d   = running && (laH_d < H_ACT) && (laV_d < V_ACT);
        column_d     = fetchAct_d ? COL_W'(laH_d) : '0;
        row_d        = fetchAct_d ? ROW_W'(laV_d) : '0;
        lineStart_d  = tick && running && (hCnt_d == '0);
        frameStart_d = lineStart_d && (vCnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_HALT;
            divCnt_q     <= '0;
            hCnt_q       <= '0;
            vCnt_q       <= '0;
            laH_q        <= LA_H0;
            laV_q        <= '0;
            pixEn_q      <= 1'b0;
            hSync_q      <= ~HS_ON;
            vSync_q      <= ~VS_ON;
            dispAct_q    <= 1'b0;
            fetchAct_q   <= 1'b0;
            column_q     <= '0;
            row_q        <= '0;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            divCnt_q     <= divCnt_d;
            hCnt_q       <= hCnt_d;
            vCnt_q       <= vCnt_d;
            laH_q        <= laH_d;
            laV_q        <= laV_d;
            pixEn_q      <= pixEn_d;
            hSync_q      <= hSync_d;
            vSync_q      <= vSync_d;
            dispAct_q    <= dispAct_d;
            fetchAct_q   <= fetchAct_d;
            column_q     <= column_d;
            row_q        <= row_d;
            lineStart_q  <= lineStart_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign pixEn         = pixEn_q;
    assign hSync         = hSync_q;
    assign vSync         = vSync_q;
    assign displayActive = dispAct_q;
    assign fetchActive   = fetchAct_q;
    assign column        = column_q;
    assign row           = row_q;
    assign lineStart     = lineStart_q;
    assign frameStart    = frameStart_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small configurations checked cycle by cycle against a
// linear-pixel-index reference model, plus a constant vector table and timing sequences.
module tb_vga_timing_gen;
    logic clk, rst, run;

    logic       pix_a, hs_a, vs_a, da_a, fa_a, ls_a, fs_a;
    logic [3:0] col_a;
    logic [2:0] row_a;
    logic       pix_b, hs_b, vs_b, da_b, fa_b, ls_b, fs_b;
    logic [3:0] col_b;
    logic [3:0] row_b;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(0), .V_POL(1), .CLK_DIV(2), .LOOKAHEAD(3), .COL_W(4), .ROW_W(3)
    ) dut_a (
        .clk(clk), .rst(rst), .run(run), .pixEn(pix_a), .hSync(hs_a), .vSync(vs_a),
        .displayActive(da_a), .fetchActive(fa_a), .column(col_a), .row(row_a),
        .lineStart(ls_a), .frameStart(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(0), .V_POL(0), .CLK_DIV(1), .LOOKAHEAD(0), .COL_W(4), .ROW_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .run(run), .pixEn(pix_b), .hSync(hs_b), .vSync(vs_b),
        .displayActive(da_b), .fetchActive(fa_b), .column(col_b), .row(row_b),
        .lineStart(ls_b), .frameStart(fs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed as {pixEn,hSync,vSync,displayActive,fetchActive,lineStart,frameStart,col[7:0],row[7:0]}
    logic [22:0] gotA, gotB;
    assign gotA = {pix_a, hs_a, vs_a, da_a, fa_a, ls_a, fs_a, 8'(col_a), 8'(row_a)};
    assign gotB = {pix_b, hs_b, vs_b, da_b, fa_b, ls_b, fs_b, 8'(col_b), 8'(row_b)};

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, hpol, vpol, div, la;
    } cfg_t;
    typedef struct {
        int n;
        bit running;
        int p;
    } mst_t;

    localparam cfg_t CA = '{8, 2, 3, 2, 5, 1, 2, 1, 0, 1, 2, 3};
    localparam cfg_t CB = '{4, 1, 1, 1, 2, 1, 1, 1, 0, 0, 1, 0};

    mst_t stA, stB;
    logic [22:0] expA, expB;
    int total = 0;
    int bad = 0;

    // Beam tracked as a linear pixel index within the frame.
    function automatic void step(input cfg_t c, inout mst_t s, input logic r, input logic ru,
                                 output logic [22:0] e);
        int ht, fr, h, v, q, lh, lv;
        bit tick, hsx, vsx, da, fa, ls, fs;
        logic [7:0] col, rw;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        fr = ht * (c.va + c.vfp + c.vs + c.vbp);
        tick = 0;
        if (!r) begin
            s.n = 0; s.running = 0; s.p = 0;
        end else begin
            s.n++;
            tick = ((s.n % c.div) == 0);
            if (tick) begin
                if (!s.running) begin
                    if (ru) begin s.running = 1; s.p = 0; end
                end else if (s.p == fr - 1 && !ru) begin
                    s.running = 0; s.p = 0;
                end else begin
                    s.p = (s.p + 1) % fr;
                end
            end
        end
        hsx = (c.hpol == 0); vsx = (c.vpol == 0);
        da = 0; fa = 0; ls = 0; fs = 0; col = 0; rw = 0;
        if (s.running) begin
            h = s.p % ht; v = s.p / ht;
            q = (s.p + c.la) % fr; lh = q % ht; lv = q / ht;
            if (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) hsx = (c.hpol != 0);
            if (v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) vsx = (c.vpol != 0);
            da = (h < c.ha) && (v < c.va);
            fa = (lh < c.ha) && (lv < c.va);
            if (fa) begin col = 8'(lh); rw = 8'(lv); end
            ls = tick && (h == 0);
            fs = ls && (v == 0);
        end
        e = {tick, hsx, vsx, da, fa, ls, fs, col, rw};
    endfunction

    task automatic check(input string nm, input logic [22:0] got, input logic [22:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        step(CA, stA, rst, run, expA);
        step(CB, stB, rst, run, expB);
        @(negedge clk);
        check("modelA", gotA, expA);
        check("modelB", gotB, expB);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return fs_a;
            1: return fs_b;
            2: return ls_b;
            default: return 1'b0;
        endcase
    endfunction

    // Cycles until the selected pulse is seen; -1 if the bound expires.
    task automatic wait_for(input int sel, input int limit, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!sig(sel) && n < limit);
        if (!sig(sel)) n = -1;
    endtask

    typedef struct {
        logic       rst, run;
        logic [6:0] flags;
        logic [3:0] col, row;
    } vec_t;

    localparam logic [22:0] RST_A = {7'b0100000, 16'h0};

    initial begin
        vec_t tbl[12];
        int n, cnt;
        rst = 1'b0;
        run = 1'b1;
        stA = '{0, 0, 0};
        stB = '{0, 0, 0};

        tbl[0]  = '{1'b0, 1'b1, 7'b0110000, 4'd0, 4'd0};
        tbl[1]  = '{1'b1, 1'b1, 7'b1111111, 4'd0, 4'd0};
        tbl[2]  = '{1'b1, 1'b1, 7'b1111100, 4'd1, 4'd0};
        tbl[3]  = '{1'b1, 1'b1, 7'b1111100, 4'd2, 4'd0};
        tbl[4]  = '{1'b1, 1'b1, 7'b1111100, 4'd3, 4'd0};
        tbl[5]  = '{1'b1, 1'b1, 7'b1110000, 4'd0, 4'd0};
        tbl[6]  = '{1'b1, 1'b1, 7'b1010000, 4'd0, 4'd0};
        tbl[7]  = '{1'b1, 1'b1, 7'b1110000, 4'd0, 4'd0};
        tbl[8]  = '{1'b1, 1'b1, 7'b1111110, 4'd0, 4'd1};
        tbl[9]  = '{1'b1, 1'b1, 7'b1111100, 4'd1, 4'd1};
        tbl[10] = '{1'b1, 1'b0, 7'b1111100, 4'd2, 4'd1};
        tbl[11] = '{1'b1, 1'b1, 7'b1111100, 4'd3, 4'd1};

        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst;
            run = tbl[i].run;
            cycle();
            check($sformatf("tableB[%0d]", i), gotB,
                  {tbl[i].flags, 4'd0, tbl[i].col, 4'd0, tbl[i].row});
        end

        // Periods between pulses
        wait_for(1, 100, n);
        wait_for(1, 100, n);
        check_int("B frame period", n, 35);
        wait_for(2, 20, n);
        check_int("B line period", n, 7);
        wait_for(0, 600, n);
        wait_for(0, 600, n);
        check_int("A frame period", n, 270);

        // Halt mid-frame, then resume
        for (int i = 0; i < 50; i++) cycle();
        run = 1'b0;
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            cycle();
            if (fs_a) cnt++;
        end
        check_int("A frameStart while halting", cnt, 0);
        check("A halted outputs", {1'b0, gotA[21:0]}, RST_A);
        run = 1'b1;
        wait_for(0, 3, n);
        check_int("A resume on next pixEn", int'(n >= 1 && n <= 2), 1);

        // Reset mid-frame
        for (int i = 0; i < 77; i++) cycle();
        rst = 1'b0;
        cycle();
        check("A reset values", gotA, RST_A);
        rst = 1'b1;
        wait_for(0, 10, n);
        check_int("A frameStart after reset", n, 2);

        // Randomised run/reset activity against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) run = ~run;
            rst = ($urandom_range(0, 599) != 0);
            cycle();
        end
        rst = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 300; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
